// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler: config FSM states,
// default base divider for a 50 MHz system clock, and a width helper.
package tick_sched_pkg;

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_TICK = 1'b1
  } sched_state_t;

  localparam int TS_BASE_DIV_50M = 50000;

  // $clog2 that never returns zero, so single-entry selectors stay one bit wide.
  function automatic int ts_clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: counts base ticks against a committed period and
// emits a one-cycle tick plus a square wave. o_en exists with TICK_SCHED_ACTIVE_EN.
module tick_channel #(
  parameter int p_period_w = 16
) (
  input  logic                  i_clk,
  input  logic                  reset,
  input  logic                  i_base_tick,
  input  logic                  i_commit,
  input  logic [p_period_w-1:0] i_period,
  output logic                  o_tick,
  output logic                  o_clk
`ifdef TICK_SCHED_ACTIVE_EN
  ,
  output logic                  o_en
`endif
);

  localparam logic [p_period_w-1:0] PERIOD_ONE = p_period_w'(1);

  logic [p_period_w-1:0] period_q, period_d;
  logic [p_period_w-1:0] cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic                  tick_q, tick_d;
  logic                  clk_q, clk_d;
  logic                  at_wrap;

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    tick_d   = 1'b0;
    clk_d    = clk_q;
    at_wrap  = (cnt_q == (period_q - PERIOD_ONE));

    // A commit restarts the phase and suppresses this base tick's strobe.
    if (i_commit) begin
      en_d  = (i_period != '0);
      cnt_d = '0;
      clk_d = 1'b0;
      if (i_period != '0) begin
        period_d = i_period;
      end
    end else if (i_base_tick && en_q) begin
      if (at_wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        clk_d  = ~clk_q;
      end else begin
        cnt_d = cnt_q + PERIOD_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      period_q <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      tick_q   <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      tick_q   <= tick_d;
      clk_q    <= clk_d;
    end
  end

  assign o_tick = tick_q;
  assign o_clk  = clk_q;

`ifdef TICK_SCHED_ACTIVE_EN
  assign o_en = en_q;
`endif

endmodule

// File: rtl/tick_scheduler.sv
// Shared rate generator: base prescaler, one-at-a-time config handshake and
// p_channels tick channels. TICK_SCHED_ACTIVE_EN adds the o_active flags port.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int p_channels = 4,
  parameter int p_base_div = TS_BASE_DIV_50M,
  parameter int p_period_w = 16,
  parameter int p_ch_w     = ts_clog2_min1(p_channels)
) (
  input  logic                  i_clk,
  input  logic                  reset,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [p_ch_w-1:0]     i_cfg_ch,
  input  logic [p_period_w-1:0] i_cfg_period,
  output logic                  o_base_tick,
  output logic [p_channels-1:0] o_tick,
  output logic [p_channels-1:0] o_clk
`ifdef TICK_SCHED_ACTIVE_EN
  ,
  output logic [p_channels-1:0] o_active
`endif
);

  localparam int                PRE_W    = ts_clog2_min1(p_base_div);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(p_base_div - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic                  base_tick_q, base_tick_d;

  sched_state_t          state_q, state_d;
  logic [p_ch_w-1:0]     pend_ch_q, pend_ch_d;
  logic [p_period_w-1:0] pend_period_q, pend_period_d;
  logic                  cfg_ready;
  logic                  commit_hit;
  logic [p_channels-1:0] ch_commit;

  always_comb begin
    base_tick_d = (pre_cnt_q == PRE_LAST);
    pre_cnt_d   = base_tick_d ? '0 : (pre_cnt_q + PRE_ONE);
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      pre_cnt_q   <= '0;
      base_tick_q <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      base_tick_q <= base_tick_d;
    end
  end

  // Commits wait for the registered base tick so every change lands on a
  // base-tick boundary; an accept coinciding with a base tick waits for the next.
  always_comb begin
    state_d       = state_q;
    pend_ch_d     = pend_ch_q;
    pend_period_d = pend_period_q;
    cfg_ready     = 1'b0;
    commit_hit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cfg_ready = reset;
        if (i_cfg_valid && cfg_ready) begin
          pend_ch_d     = i_cfg_ch;
          pend_period_d = i_cfg_period;
          state_d       = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (base_tick_q) begin
          commit_hit = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pend_ch_q     <= '0;
      pend_period_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_ch_q     <= pend_ch_d;
      pend_period_q <= pend_period_d;
    end
  end

  assign o_cfg_ready = cfg_ready;
  assign o_base_tick = base_tick_q;

`ifdef TICK_SCHED_ACTIVE_EN
  logic [p_channels-1:0] ch_en;
  assign o_active = ch_en;
`endif

  // Out-of-range channel indices match no instance, so the commit is dropped.
  for (genvar gi = 0; gi < p_channels; gi++) begin : g_ch
    localparam logic [p_ch_w-1:0] CH_IDX = p_ch_w'(gi);

    assign ch_commit[gi] = commit_hit && (pend_ch_q == CH_IDX);

    tick_channel #(
      .p_period_w (p_period_w)
    ) u_channel (
      .i_clk       (i_clk),
      .reset       (reset),
      .i_base_tick (base_tick_q),
      .i_commit    (ch_commit[gi]),
      .i_period    (pend_period_q),
      .o_tick      (o_tick[gi]),
      .o_clk       (o_clk[gi])
`ifdef TICK_SCHED_ACTIVE_EN
      ,
      .o_en        (ch_en[gi])
`endif
    );
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shared rate-generation controller: one base prescaler divides `i_clk` down to a base tick, and N independent channels count base ticks against runtime-programmed periods. Each channel produces a one-cycle tick strobe and a 50 % square wave. Channels are configured one at a time over a valid/ready handshake, and each change is committed glitch-free on a base-tick boundary. It replaces per-consumer fixed dividers wherever several slow rates (blink, debounce sample, display refresh) are needed from the 50 MHz system clock.

## Interface
- `p_channels`, default 4: number of channels, 1..16.
- `p_base_div`, default 50000: `i_clk` cycles per base tick (50 MHz gives 1 kHz); must be ≥ 2.
- `p_period_w`, default 16: width of the channel period field.
- `i_clk`, in, 1: system clock; everything is on its rising edge.
- `reset`, in, 1: reset, synchronous and active-low.
- `i_cfg_valid`, in, 1: configuration request.
- `o_cfg_ready`, out, 1: scheduler can accept a request.
- `i_cfg_ch`, in, `$clog2(p_channels)` (min 1): target channel.
- `i_cfg_period`, in, `p_period_w`: period in base ticks; 0 disables the channel.
- `o_base_tick`, out, 1: one-cycle strobe per base period.
- `o_tick`, out, `p_channels`: per-channel one-cycle strobe.
- `o_clk`, out, `p_channels`: per-channel square wave, toggles on each channel tick.

## Operation
- **Prescaler:** counter runs 0..`p_base_div`-1. `o_base_tick` is registered and high for exactly one cycle after each wrap.
- **Channel, per base tick while enabled:**
  - if cnt == period-1: set cnt to 0, pulse `o_tick[i]`, toggle `o_clk[i]`;
  - otherwise increment cnt.
  - Tick interval = period base ticks; `o_clk` period = 2×period base ticks.
- **Config FSM states:** S_IDLE, S_WAIT_TICK.
  - S_IDLE: `o_cfg_ready`=1. On valid && ready, latch ch and period into the pending register, then go to S_WAIT_TICK.
  - S_WAIT_TICK: `o_cfg_ready`=0. In the cycle `o_base_tick`=1, commit the pending register and return to S_IDLE.
- **Commit to channel i:**
  - period≠0: store period, cnt=0, `o_clk[i]`=0, enabled=1.
  - period=0: enabled=0, cnt=0, `o_clk[i]`=0.
  - The committed channel produces no `o_tick` on the commit base tick. Other channels count normally on that tick.
- **Out-of-range `i_cfg_ch` (≥ `p_channels`):** request is accepted and walks through S_WAIT_TICK, but the commit is dropped. No channel changes.
- **Reconfiguring a running channel:** restarts its phase from zero. There is no partial-period carry-over.
- **Reset values:** prescaler 0, all channels disabled with cnt 0, `o_base_tick`=0, `o_tick`=0, `o_clk`=0, FSM in S_IDLE. `o_cfg_ready` is forced 0 while `reset` is low.
- **Reset mid-operation:** pending config is discarded. Requests with `reset` low are ignored.

## Timing
- Prescaler wraps at cycle k; `o_base_tick` is high at k+1.
- Channel wrap evaluated with `o_base_tick` high at cycle t drives `o_tick`/`o_clk` at t+1.
- Handshake accepted at cycle a: commit occurs at the first cycle c > a with `o_base_tick`=1.
  - `o_cfg_ready` returns at c+1.
  - Worst-case stall is `p_base_div`+1 cycles.
- An accept in the same cycle as `o_base_tick`=1 waits for the next base tick.
- Throughput: at most one configuration per base tick.

## Configuration
- Macro `TICK_SCHED_ACTIVE_EN`:
  - Defined: adds output port `o_active` [`p_channels`], registered per-channel enabled flags, reset 0, updated on commit.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `tick_sched_pkg`: FSM enum typedef `sched_state_t` (S_IDLE, S_WAIT_TICK) and the default base-divider constant `TS_BASE_DIV_50M` = 50000.
- Sub-module `tick_channel`: period register, counter, enable flag, `o_tick`/`o_clk` registers, and a commit port. Instantiated `p_channels` times via generate.
- Prescaler and FSM live in the top level.

## Test plan
All scenarios use `p_base_div`=4, `p_channels`=4.
1. **Reset:** hold `reset` low 5 cycles with `i_cfg_valid`=1 → all outputs 0, `o_cfg_ready`=0, no accept. After release, `o_cfg_ready`=1 and `o_base_tick` pulses every 4 cycles.
2. **Basic channel:** configure ch0 period 3 → `o_cfg_ready` low until the next base tick. Then `o_tick[0]` pulses every 12 cycles and `o_clk[0]` has a 24-cycle period starting low.
3. **Minimum period:** configure ch1 period 1 → `o_tick[1]` on every base tick and `o_clk[1]` toggles every 4 cycles. Then period 0 → ticks stop, `o_clk[1]` held 0.
4. **Back-to-back configs:** ch2 then ch3 with `i_cfg_valid` held → second accepted only after the first commits; ch0 tick spacing stays exactly 12 cycles throughout.
5. **Reset during wait:** assert `reset` while in S_WAIT_TICK holding a ch2 config → after release ch2 is disabled and no `o_tick[2]` ever occurs.
6. **Out-of-range channel:** configure ch index 5 (with `p_channels`=4, widened index) → handshake completes, all channel outputs unchanged.
